// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: word width, predecode opcodes and FSM encoding.
package fetch_unit_pkg;

    localparam int WORD = 16;

    localparam logic [3:0] OP_NOARG = 4'h0;
    localparam logic [3:0] OP_CALL  = 4'hC;
    localparam logic [3:0] OP_JUMP  = 4'hD;
    localparam logic [3:0] OP_JUMPF = 4'hE;
    localparam logic [3:0] OP_ADDR  = 4'hF;
    localparam logic [3:0] SUB_RET  = 4'h1;

    typedef enum logic [1:0] {
        ST_NORMAL    = 2'd0,
        ST_ADDR_CALL = 2'd1,
        ST_ADDR_JUMP = 2'd2
    } state_t;

    function automatic logic is_ret(input logic [WORD-1:0] w);
        return (w[15:12] == OP_NOARG) && (w[3:0] == SUB_RET);
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: LIFO that drops its oldest entry when pushed while full,
// with sticky overflow/underflow flags.
module ras_stack
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [WORD-1:0] i_din,
    output logic [WORD-1:0] o_dout,
    output logic            o_empty,
    output logic            o_ovf,
    output logic            o_unf
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WORD-1:0] r_mem [DEPTH];
    logic [CW-1:0]   r_cnt;
    logic            r_ovf;
    logic            r_unf;
    logic            w_full;

    assign o_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == CW'(DEPTH));
    assign o_ovf   = r_ovf;
    assign o_unf   = r_unf;

    always_comb begin
        o_dout = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_cnt == CW'(i + 1)) o_dout = r_mem[i];
        end
    end

    // Entry 0 is always the oldest; a full push shifts everything down one slot.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (i_push) begin
            if (w_full) begin
                for (int i = 0; i < DEPTH - 1; i++) r_mem[i] <= r_mem[i+1];
                r_mem[DEPTH-1] <= i_din;
                r_ovf          <= 1'b1;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_cnt == CW'(i)) r_mem[i] <= i_din;
                end
                r_cnt <= r_cnt + CW'(1);
            end
        end else if (i_pop) begin
            if (o_empty) r_unf <= 1'b1;
            else         r_cnt <= r_cnt - CW'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, call/jump/ret predecode with return-address stack,
// downstream redirect, and the registered decode interface.
//
//  state        | meaning
//  ST_NORMAL    | fetching ordinary words; call/jump start a two-word sequence
//  ST_ADDR_CALL | next word carries the high target byte of a call
//  ST_ADDR_JUMP | next word carries the high target byte of a jump
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [WORD-1:0] RESET_PC  = 16'h0000,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    output logic [WORD-1:0] o_imem_addr,
    input  logic [WORD-1:0] i_imem_rdata,
    input  logic            i_stall,
    input  logic            i_halt,
    input  logic            i_redirect_valid,
    input  logic [WORD-1:0] i_redirect_pc,
    output logic            o_if_valid,
    output logic [WORD-1:0] o_if_ir,
    output logic [WORD-1:0] o_if_pc,
    output logic            o_ras_overflow,
    output logic            o_ras_underflow
);
    state_t          r_state;
    logic [WORD-1:0] r_pc;
    logic [7:0]      r_lo;
    logic            r_halted;
    logic            r_if_valid;
    logic [WORD-1:0] r_if_ir;
    logic [WORD-1:0] r_if_pc;

    state_t          w_state_nxt;
    logic [WORD-1:0] w_pc_nxt;
    logic [WORD-1:0] w_pc_inc;
    logic [7:0]      w_lo_nxt;
    logic [3:0]      w_op;
    logic            w_advance;
    logic            w_push;
    logic            w_pop;
    logic [WORD-1:0] w_ras_dout;
    logic            w_ras_empty;

    assign o_imem_addr = r_pc;
    assign o_if_valid  = r_if_valid;
    assign o_if_ir     = r_if_ir;
    assign o_if_pc     = r_if_pc;

    assign w_op      = i_imem_rdata[15:12];
    assign w_pc_inc  = r_pc + 16'd1;
    // A retired trap freezes the stage until reset, even once i_halt drops.
    assign w_advance = !i_redirect_valid && !i_halt && !r_halted && !i_stall;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_lo_nxt    = r_lo;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        if (i_redirect_valid) begin
            w_pc_nxt    = i_redirect_pc;
            w_state_nxt = ST_NORMAL;
        end else if (w_advance) begin
            case (r_state)
                ST_NORMAL: begin
                    if (w_op == OP_CALL) begin
                        w_pc_nxt    = w_pc_inc;
                        w_lo_nxt    = i_imem_rdata[7:0];
                        w_state_nxt = ST_ADDR_CALL;
                    end else if (w_op == OP_JUMP) begin
                        w_pc_nxt    = w_pc_inc;
                        w_lo_nxt    = i_imem_rdata[7:0];
                        w_state_nxt = ST_ADDR_JUMP;
                    end else if (is_ret(i_imem_rdata)) begin
                        w_pop    = 1'b1;
                        w_pc_nxt = w_ras_empty ? RESET_PC : w_ras_dout;
                    end else begin
                        w_pc_nxt = w_pc_inc;
                    end
                end
                ST_ADDR_CALL, ST_ADDR_JUMP: begin
                    w_state_nxt = ST_NORMAL;
                    if (w_op == OP_ADDR) begin
                        w_pc_nxt = {i_imem_rdata[7:0], r_lo};
                        w_push   = (r_state == ST_ADDR_CALL);
                    end else begin
                        w_pc_nxt = w_pc_inc;
                    end
                end
                default: w_state_nxt = ST_NORMAL;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_NORMAL;
            r_pc       <= RESET_PC;
            r_lo       <= '0;
            r_halted   <= 1'b0;
            r_if_valid <= 1'b0;
            r_if_ir    <= '0;
            r_if_pc    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_lo     <= w_lo_nxt;
            r_halted <= r_halted | i_halt;
            if (i_redirect_valid) begin
                r_if_valid <= 1'b0;
            end else if (w_advance) begin
                r_if_valid <= 1'b1;
                r_if_ir    <= i_imem_rdata;
                r_if_pc    <= r_pc;
            end
        end
    end

    ras_stack #(
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_pc_inc),
        .o_dout  (w_ras_dout),
        .o_empty (w_ras_empty),
        .o_ovf   (o_ras_overflow),
        .o_unf   (o_ras_underflow)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus randomized traffic against a
// queue-based reference model of the fetch rules.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        stall = 1'b0;
    logic        halt = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        if_valid;
    logic [15:0] if_ir;
    logic [15:0] if_pc;
    logic        ras_overflow;
    logic        ras_underflow;

    logic [15:0] imem [0:65535];
    assign imem_rdata = imem[imem_addr];

    fetch_unit #(.RESET_PC(16'h0000), .RAS_DEPTH(4)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .o_imem_addr      (imem_addr),
        .i_imem_rdata     (imem_rdata),
        .i_stall          (stall),
        .i_halt           (halt),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_if_valid       (if_valid),
        .o_if_ir          (if_ir),
        .o_if_pc          (if_pc),
        .o_ras_overflow   (ras_overflow),
        .o_ras_underflow  (ras_underflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model state: mode 0 = ordinary, 1 = awaiting call address, 2 = awaiting jump address.
    logic [15:0] m_pc, m_ir, m_ipc;
    logic        m_valid, m_ovf, m_unf, m_halted;
    logic [7:0]  m_lo;
    int          m_mode;
    logic [15:0] m_stack [$];

    wire [50:0] dut_vec = {imem_addr, if_valid, if_ir, if_pc, ras_overflow, ras_underflow};

    function automatic logic [50:0] model_vec();
        return {m_pc, m_valid, m_ir, m_ipc, m_ovf, m_unf};
    endfunction

    task automatic model_reset();
        m_pc = 16'h0000; m_ir = 16'h0; m_ipc = 16'h0; m_valid = 1'b0;
        m_ovf = 1'b0; m_unf = 1'b0; m_halted = 1'b0; m_lo = 8'h0; m_mode = 0;
        m_stack.delete();
    endtask

    task automatic model_step(input bit st, input bit hl, input bit rd, input logic [15:0] rp);
        logic [15:0] w;
        if (rd) begin
            m_pc = rp; m_valid = 1'b0; m_mode = 0;
        end else if (!(hl || m_halted || st)) begin
            w = imem[m_pc];
            m_ir = w; m_ipc = m_pc; m_valid = 1'b1;
            if (m_mode == 0) begin
                if (w[15:12] == 4'hC) begin
                    m_lo = w[7:0]; m_pc = m_pc + 16'd1; m_mode = 1;
                end else if (w[15:12] == 4'hD) begin
                    m_lo = w[7:0]; m_pc = m_pc + 16'd1; m_mode = 2;
                end else if (w[15:12] == 4'h0 && w[3:0] == 4'h1) begin
                    if (m_stack.size() == 0) begin
                        m_pc = 16'h0000; m_unf = 1'b1;
                    end else begin
                        m_pc = m_stack.pop_back();
                    end
                end else begin
                    m_pc = m_pc + 16'd1;
                end
            end else begin
                if (w[15:12] == 4'hF) begin
                    if (m_mode == 1) begin
                        if (m_stack.size() == 4) begin
                            void'(m_stack.pop_front());
                            m_ovf = 1'b1;
                        end
                        m_stack.push_back(m_pc + 16'd1);
                    end
                    m_pc = {w[7:0], m_lo};
                end else begin
                    m_pc = m_pc + 16'd1;
                end
                m_mode = 0;
            end
        end
        if (hl) m_halted = 1'b1;
    endtask

    task automatic tick(input bit st, input bit hl, input bit rd, input logic [15:0] rp);
        stall = st; halt = hl; redirect_valid = rd; redirect_pc = rp;
        model_step(st, hl, rd, rp);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #3;
        total++; if (imem_addr !== 16'h0000) begin bad++; $display("FAIL reset_pc: got %h want 0000", imem_addr); end
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", if_valid); end
        total++; if ({if_ir, if_pc} !== 32'h0) begin bad++; $display("FAIL reset_ir_pc: got %h want 0", {if_ir, if_pc}); end
        total++; if ({ras_overflow, ras_underflow} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {ras_overflow, ras_underflow}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(0, 0, 1, 16'h0041);
        tick(0, 0, 0, 16'h0);
        total++; if (imem_addr !== 16'h0042 || if_valid !== 1'b1) begin bad++; $display("FAIL pre_reset: got pc=%h v=%b want pc=0042 v=1", imem_addr, if_valid); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (imem_addr !== 16'h0000 || if_valid !== 1'b0) begin bad++; $display("FAIL async_reset: got pc=%h v=%b want pc=0000 v=0", imem_addr, if_valid); end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        logic [15:0] words [3];
        words[0] = 16'h1123; words[1] = 16'h2456; words[2] = 16'h3789;
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 16'h0);
            total++;
            if (if_ir !== words[i] || if_pc !== 16'(i) || if_valid !== 1'b1)
                begin bad++; $display("FAIL seq_%0d: got ir=%h pc=%h v=%b want ir=%h pc=%h v=1", i, if_ir, if_pc, if_valid, words[i], 16'(i)); end
        end
    endtask

    task automatic test_call_ret();
        tick(0, 0, 0, 16'h0);
        tick(0, 0, 0, 16'h0);
        tick(0, 0, 0, 16'h0);
        total++; if (imem_addr !== 16'h1234) begin bad++; $display("FAIL call_target: got %h want 1234", imem_addr); end
        total++; if (if_ir !== 16'hF012 || if_pc !== 16'h0005 || if_valid !== 1'b1) begin bad++; $display("FAIL call_addr_word: got ir=%h pc=%h v=%b want ir=f012 pc=0005 v=1", if_ir, if_pc, if_valid); end
        tick(0, 0, 0, 16'h0);
        total++; if (imem_addr !== 16'h0006 || if_pc !== 16'h1234) begin bad++; $display("FAIL ret_target: got pc=%h if_pc=%h want 0006/1234", imem_addr, if_pc); end
    endtask

    task automatic test_stall_redirect();
        tick(1, 0, 1, 16'h0100);
        total++; if (imem_addr !== 16'h0100 || if_valid !== 1'b0) begin bad++; $display("FAIL stall_redirect: got pc=%h v=%b want 0100/0", imem_addr, if_valid); end
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 0, 16'h0);
            total++;
            if (if_ir !== 16'h0001 || if_pc !== 16'h1234 || imem_addr !== 16'h0100)
                begin bad++; $display("FAIL stall_hold_%0d: got ir=%h ifpc=%h pc=%h want 0001/1234/0100", i, if_ir, if_pc, imem_addr); end
        end
    endtask

    task automatic test_ras_bounds();
        tick(0, 0, 1, 16'h0300);
        for (int i = 0; i < 8; i++) tick(0, 0, 0, 16'h0);
        total++; if (ras_overflow !== 1'b0) begin bad++; $display("FAIL ovf_at_depth: got %b want 0", ras_overflow); end
        tick(0, 0, 0, 16'h0);
        tick(0, 0, 0, 16'h0);
        total++; if (ras_overflow !== 1'b1 || imem_addr !== 16'h0400) begin bad++; $display("FAIL ovf_set: got ovf=%b pc=%h want 1/0400", ras_overflow, imem_addr); end
        for (int k = 4; k >= 1; k--) begin
            tick(0, 0, 0, 16'h0);
            total++;
            if (imem_addr !== 16'(16'h0300 + 16'h10 * k + 2))
                begin bad++; $display("FAIL ras_ret_%0d: got %h want %h", k, imem_addr, 16'(16'h0300 + 16'h10 * k + 2)); end
        end
        total++; if (ras_underflow !== 1'b0) begin bad++; $display("FAIL unf_early: got %b want 0", ras_underflow); end
        tick(0, 0, 0, 16'h0);
        total++; if (imem_addr !== 16'h0000 || ras_underflow !== 1'b1) begin bad++; $display("FAIL underflow: got pc=%h unf=%b want 0000/1", imem_addr, ras_underflow); end
    endtask

    task automatic test_random();
        bit st, rd;
        for (int i = 0; i < 400; i++) begin
            st = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 9) == 0);
            tick(st, 0, rd, 16'($urandom));
            total++;
            if (dut_vec !== model_vec())
                begin bad++; $display("FAIL random_%0d: got %h want %h", i, dut_vec, model_vec()); end
        end
    endtask

    task automatic test_halt();
        tick(0, 1, 0, 16'h0);
        total++; if (dut_vec !== model_vec()) begin bad++; $display("FAIL halt_edge: got %h want %h", dut_vec, model_vec()); end
        for (int i = 0; i < 10; i++) begin
            tick(0, (i < 3), 0, 16'h0);
            total++;
            if (dut_vec !== model_vec())
                begin bad++; $display("FAIL halt_hold_%0d: got %h want %h", i, dut_vec, model_vec()); end
        end
    endtask

    initial begin
        logic [15:0] b, nxt;
        for (int a = 0; a < 65536; a++) imem[a] = 16'($urandom);
        imem[0] = 16'h1123; imem[1] = 16'h2456; imem[2] = 16'h3789; imem[3] = 16'h3003;
        imem[4] = 16'hC034; imem[5] = 16'hF012; imem[16'h1234] = 16'h0001;
        imem[16'h0041] = 16'h1041; imem[16'h0042] = 16'h1042;
        for (int k = 0; k < 5; k++) begin
            b   = 16'(16'h0300 + 16'h10 * k);
            nxt = (k == 4) ? 16'h0400 : 16'(b + 16'h10);
            imem[b]              = {8'hC0, nxt[7:0]};
            imem[16'(b + 16'd1)] = {8'hF0, nxt[15:8]};
            imem[16'(b + 16'd2)] = 16'h0001;
        end
        imem[16'h0400] = 16'h0001;

        test_reset();
        test_sequential();
        test_call_ret();
        test_stall_redirect();
        test_ras_bounds();
        test_random();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
